// File: rtl/operand_shifter.sv
// Multi-cycle ARM operand-2 barrel shifter: one bit per clock, valid/ready on both sides.
// Produces the shifted operand and shifter carry-out for the data-processing ALU.
module operand_shifter #(
    parameter int WordWidth = 32,
    parameter int AmtWidth  = 8,
    parameter int CntWidth  = 6
) (
    input  logic                 in_Clk,
    input  logic                 in_Rst_N,
    input  logic                 in_Valid,
    output logic                 out_Ready,
    input  logic [WordWidth-1:0] in_Value,
    input  logic [AmtWidth-1:0]  in_Amount,
    input  logic [1:0]           in_Type,
    input  logic                 in_AmtIsImm,
    input  logic                 in_CarryIn,
    input  logic                 in_Flush,
    output logic                 out_Valid,
    input  logic                 in_Ready,
    output logic [WordWidth-1:0] out_Op2,
    output logic                 out_Carry
);

    localparam logic [1:0] TypeLsl = 2'b00;
    localparam logic [1:0] TypeLsr = 2'b01;
    localparam logic [1:0] TypeAsr = 2'b10;
    localparam logic [1:0] TypeRor = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q;
    logic [1:0]            type_q;
    logic                  rrx_q;
    logic                  cin_q;

    logic                  accept;
    logic [CntWidth-1:0]   iter_n;
    logic                  is_rrx;
    logic                  init_carry;
    logic [WordWidth:0]    step_res;

    // Iteration count: LSL/LSR saturate at 33 so >32 falls out as C=0, ASR at 32.
    function automatic logic [CntWidth-1:0] iter_count(input logic [AmtWidth-1:0] amt,
                                                       input logic [1:0] typ,
                                                       input logic is_imm);
        logic [4:0] a5;
        logic [CntWidth-1:0] n;
        a5 = amt[4:0];
        n  = '0;
        if (is_imm) begin
            case (typ)
                TypeLsl: n = CntWidth'(a5);
                TypeLsr, TypeAsr: n = (a5 == 5'd0) ? CntWidth'(32) : CntWidth'(a5);
                default: n = (a5 == 5'd0) ? CntWidth'(1) : CntWidth'(a5);
            endcase
        end else begin
            case (typ)
                TypeLsl, TypeLsr: n = (amt > AmtWidth'(33)) ? CntWidth'(33) : CntWidth'(amt);
                TypeAsr: n = (amt > AmtWidth'(32)) ? CntWidth'(32) : CntWidth'(amt);
                default: n = CntWidth'(a5);
            endcase
        end
        return n;
    endfunction

    // One shift step; returns {carry_out, shifted_word}.
    function automatic logic [WordWidth:0] shift_step(input logic [WordWidth-1:0] op,
                                                      input logic [1:0] typ,
                                                      input logic rrx,
                                                      input logic cin);
        logic [WordWidth:0] r;
        case (typ)
            TypeLsl: r = {op[WordWidth-1], op[WordWidth-2:0], 1'b0};
            TypeLsr: r = {op[0], 1'b0, op[WordWidth-1:1]};
            TypeAsr: r = {op[0], op[WordWidth-1], op[WordWidth-1:1]};
            default: r = {op[0], (rrx ? cin : op[0]), op[WordWidth-1:1]};
        endcase
        return r;
    endfunction

    assign accept   = (state_q == IDLE) && in_Valid && !in_Flush;
    assign iter_n   = iter_count(in_Amount, in_Type, in_AmtIsImm);
    assign is_rrx   = in_AmtIsImm && (in_Type == TypeRor) && (in_Amount[4:0] == 5'd0);
    // Register ROR by a non-zero multiple of 32 leaves the word but reports bit 31.
    assign init_carry = (!in_AmtIsImm && (in_Type == TypeRor) && (in_Amount != '0) &&
                         (in_Amount[4:0] == 5'd0)) ? in_Value[WordWidth-1] : in_CarryIn;
    assign step_res = shift_step(out_Op2, type_q, rrx_q, cin_q);

    assign out_Ready = (state_q == IDLE);
    assign out_Valid = (state_q == DONE);

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (iter_n == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (in_Flush)                       state_d = IDLE;
                else if (cnt_q == CntWidth'(1))     state_d = DONE;
            end
            DONE: begin
                if (in_Flush || in_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            out_Op2   <= '0;
            out_Carry <= 1'b0;
            cnt_q     <= '0;
            type_q    <= 2'b00;
            rrx_q     <= 1'b0;
            cin_q     <= 1'b0;
        end else if (accept) begin
            out_Op2   <= in_Value;
            out_Carry <= init_carry;
            cnt_q     <= iter_n;
            type_q    <= in_Type;
            rrx_q     <= is_rrx;
            cin_q     <= in_CarryIn;
        end else if (state_q == SHIFT && !in_Flush) begin
            out_Carry <= step_res[WordWidth];
            out_Op2   <= step_res[WordWidth-1:0];
            cnt_q     <= cnt_q - CntWidth'(1);
        end
    end

endmodule

// File: tb/tb_operand_shifter.sv
// Randomized and directed bench for operand_shifter against an arithmetic ARM-shift model.
module tb_operand_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [31:0] in_value;
    logic [7:0]  in_amount;
    logic [1:0]  in_type;
    logic        in_imm, in_cin, in_flush;
    logic        out_valid, in_ready;
    logic [31:0] out_op2;
    logic        out_carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_shifter dut (
        .in_Clk(clk), .in_Rst_N(rst_n), .in_Valid(in_valid), .out_Ready(out_ready),
        .in_Value(in_value), .in_Amount(in_amount), .in_Type(in_type),
        .in_AmtIsImm(in_imm), .in_CarryIn(in_cin), .in_Flush(in_flush),
        .out_Valid(out_valid), .in_Ready(in_ready), .out_Op2(out_op2), .out_Carry(out_carry)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ARM shifter semantics with plain arithmetic; lat = edges from accept to out_Valid.
    task automatic model(input logic [31:0] v, input logic [7:0] amt, input logic [1:0] t,
                         input logic imm, input logic cin,
                         output logic [31:0] r, output logic c, output int lat);
        int n;
        int k;
        n = imm ? int'(amt[4:0]) : int'(amt);
        r = v;
        c = cin;
        lat = 1;
        if (imm && n == 0 && (t == 2'b01 || t == 2'b10)) n = 32;
        if (imm && n == 0 && t == 2'b11) begin
            r = {cin, v[31:1]};
            c = v[0];
            lat = 2;
        end else if (n != 0) begin
            case (t)
                2'b00: begin
                    if (n < 32)       begin r = v << n; c = v[32-n]; end
                    else if (n == 32) begin r = 0; c = v[0]; end
                    else              begin r = 0; c = 0; end
                    lat = (n > 33 ? 33 : n) + 1;
                end
                2'b01: begin
                    if (n < 32)       begin r = v >> n; c = v[n-1]; end
                    else if (n == 32) begin r = 0; c = v[31]; end
                    else              begin r = 0; c = 0; end
                    lat = (n > 33 ? 33 : n) + 1;
                end
                2'b10: begin
                    if (n >= 32) begin r = {32{v[31]}}; c = v[31]; end
                    else         begin r = $signed(v) >>> n; c = v[n-1]; end
                    lat = (n > 32 ? 32 : n) + 1;
                end
                default: begin
                    k = n % 32;
                    if (k == 0) begin r = v; c = v[31]; lat = 1; end
                    else begin r = (v >> k) | (v << (32 - k)); c = v[k-1]; lat = k + 1; end
                end
            endcase
        end
    endtask

    task automatic start_op(input logic [31:0] v, input logic [7:0] amt, input logic [1:0] t,
                            input logic imm, input logic cin);
        @(negedge clk);
        check("ready_before_accept", out_ready, 1'b1);
        in_value = v; in_amount = amt; in_type = t; in_imm = imm; in_cin = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble the request inputs: the block must have latched them.
        in_value = $urandom; in_amount = 8'($urandom); in_type = 2'($urandom);
        in_imm = 1'($urandom); in_cin = 1'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [31:0] v, input logic [7:0] amt,
                          input logic [1:0] t, input logic imm, input logic cin, input int hold);
        logic [31:0] er;
        logic        ec;
        int          el;
        int          edges;
        model(v, amt, t, imm, cin, er, ec, el);
        start_op(v, amt, t, imm, cin);
        edges = 1;
        while (!out_valid && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_lat"}, 64'(edges), 64'(el));
        check({tag, "_op2"}, out_op2, er);
        check({tag, "_c"}, out_carry, ec);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_vld"}, out_valid, 1'b1);
            check({tag, "_hold_rdy"}, out_ready, 1'b0);
            check({tag, "_hold_op2"}, out_op2, er);
            check({tag, "_hold_c"}, out_carry, ec);
        end
        @(negedge clk);
        in_ready = 1'b1;
        @(posedge clk); #1;
        in_ready = 1'b0;
        check({tag, "_drain_vld"}, out_valid, 1'b0);
        check({tag, "_drain_rdy"}, out_ready, 1'b1);
        check({tag, "_idle_op2"}, out_op2, er);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; in_value = 0; in_amount = 0; in_type = 0;
        in_imm = 0; in_cin = 0; in_flush = 0; in_ready = 0;
        #12;
        check("rst_vld", out_valid, 1'b0);
        check("rst_rdy", out_ready, 1'b1);
        check("rst_op2", out_op2, 32'h0);
        check("rst_c", out_carry, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        run_op("lsl1",    32'h8000_0001, 8'd1,   2'b00, 1'b0, 1'b0, 0);
        run_op("lsr32",   32'h8000_0001, 8'd32,  2'b01, 1'b0, 1'b0, 0);
        run_op("lsr40",   32'h8000_0001, 8'd40,  2'b01, 1'b0, 1'b0, 0);
        run_op("lsr0",    32'h8000_0001, 8'd0,   2'b01, 1'b0, 1'b1, 0);
        run_op("asri0",   32'h8000_0000, 8'd0,   2'b10, 1'b1, 1'b0, 0);
        run_op("asr200",  32'h7FFF_FFFF, 8'd200, 2'b10, 1'b0, 1'b1, 0);
        run_op("ror4",    32'h0000_00F1, 8'd4,   2'b11, 1'b0, 1'b1, 0);
        run_op("ror64",   32'h8000_0000, 8'd64,  2'b11, 1'b0, 1'b0, 0);
        run_op("rrx",     32'h0000_0003, 8'd0,   2'b11, 1'b1, 1'b1, 0);
        run_op("lsli0",   32'h1234_5678, 8'd0,   2'b00, 1'b1, 1'b1, 0);
        run_op("bp",      32'hDEAD_BEEF, 8'd7,   2'b11, 1'b0, 1'b0, 5);

        // Flush during SHIFT of LSL 20.
        start_op(32'h0000_0FFF, 8'd20, 2'b00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); in_flush = 1'b1;
        @(posedge clk); #1; in_flush = 1'b0;
        check("flush_rdy", out_ready, 1'b1);
        check("flush_vld", out_valid, 1'b0);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            check("flush_novld", out_valid, 1'b0);
        end
        run_op("post_flush", 32'hCAFE_F00D, 8'd3, 2'b10, 1'b0, 1'b0, 0);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        in_valid = 1'b1; in_flush = 1'b1; in_amount = 8'd0; in_imm = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_flush = 1'b0;
        check("idle_flush_rdy", out_ready, 1'b1);
        @(posedge clk); #1;
        check("idle_flush_vld", out_valid, 1'b0);

        // Async reset mid-SHIFT, no clock edge needed.
        start_op(32'hFFFF_FFFF, 8'd20, 2'b00, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", out_valid, 1'b0);
        check("arst_rdy", out_ready, 1'b1);
        check("arst_op2", out_op2, 32'h0);
        check("arst_c", out_carry, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 150; i++) begin
            logic [7:0] a;
            a = (i % 2 == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            run_op("rnd", $urandom, a, 2'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
